xor_frame_cipher: RTL and testbench
===================================

# xor_frame_cipher

Parametrised framed XOR cipher engine that sits between the UART_Receiver and UART_Sender byte interfaces. It receives a framed request (mode, data, key), encrypts or decrypts it with a repeating key, and returns a length-prefixed result. It adds two features the first-generation block lacks: an optional chained (CBC-style) mode and frame-length validation. It exposes plaintext and result buffers through a registered read port for the LED/button display logic.

## Interface
- MAX_DATA, 100: data buffer depth in bytes (1..255)
- MAX_KEY, 4: key buffer depth in bytes (1..16)
- Clk_100M  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from UART_Receiver
- rx_ready  in  1  receiver byte-valid
- rx_ack  out  1  receiver acknowledge
- tx_data  out  8  byte to UART_Sender
- tx_send  out  1  one-cycle send strobe
- tx_busy  in  1  sender busy
- view_idx  in  8  display read index
- view_plain  out  8  stored input byte at view_idx, registered
- view_result  out  8  result byte at view_idx, registered
- busy  out  1  high outside IDLE
- err  out  1  sticky frame error
- frame_done  out  1  one-cycle pulse after the last result byte is handed to the sender

## Operation
- Frame format, in order:
  - H: header; bit0 = chain, bit1 = decrypt, bits 7:2 ignored
  - N: data length
  - N data bytes
  - K: key length
  - K key bytes
- Response: N, then N result bytes. On error the response is the single byte 0x00.
- States: IDLE → GET_LEN → GET_DATA → GET_KLEN → GET_KEY → CRYPT → SEND_LEN → SEND_DATA → IDLE; SEND_ERR → IDLE.
- IDLE: the header byte is latched, err is cleared, and the state moves to GET_LEN.
- GET_LEN: N==0 or N>MAX_DATA → SEND_ERR.
- GET_KLEN: K==0 or K>MAX_KEY → SEND_ERR.
- Byte i (0..N-1) uses key k = key[i mod K]; the key index wraps K-1 → 0.
- Mode chain=0: r[i] = d[i]^k.
- Mode chain=1, encrypt: r[i] = d[i]^k^r[i-1].
- Mode chain=1, decrypt: r[i] = d[i]^k^d[i-1].
- The chaining value for i=0 is 0x00.
- With chain=0 the decrypt bit has no effect.
- Results are written to the result buffer and also sent.
- The buffers retain contents after a frame and are overwritten only by the next valid data phase.
- view_idx ≥ MAX_DATA reads 0x00.

## Timing
- Reset values:
  - rx_ack=0, tx_send=0, tx_data=0x00
  - busy=0, err=0, frame_done=0
  - view_plain=0x00, view_result=0x00
  - state=IDLE, counters=0
  - Buffer contents are undefined after reset.
- Rx handshake:
  - A byte is accepted on the cycle rx_ready=1 and rx_ack=0 in a receive state; rx_ack rises the next cycle.
  - rx_ack holds until rx_ready=0 and then drops the following cycle.
  - In CRYPT/SEND states rx_ack stays 0, so the receiver holds the byte until IDLE.
- CRYPT: one byte per cycle, N cycles total. SEND_LEN is entered the cycle after byte N-1.
- Tx handshake:
  - tx_send pulses for exactly one cycle with tx_data valid, only when tx_busy=0.
  - The next strobe requires tx_busy to have been observed 1 and then 0.
  - Back-to-back strobes without an observed busy cycle are forbidden.
- frame_done pulses the cycle after the final strobe; the state returns to IDLE the same cycle. busy deasserts then.
- SEND_ERR: err=1 the cycle the bad length is latched, the 0x00 byte is sent, then IDLE. err holds until the next header.
- The view port has 1-cycle latency from view_idx.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously); the partial frame is discarded.
- Counters are 8-bit; N=MAX_DATA=255 must not overflow the index compare.

## Test plan
- Basic: H=00, N=03, 41 42 43, K=01, 20 → tx 03 61 62 63; frame_done once; view_idx=1 → view_plain=42, view_result=62.
- Key wrap: H=00, N=05, 00×5, K=02, 0F F0 → tx 05 0F F0 0F F0 0F.
- Chain round trip:
  - Encrypt: H=01, N=02, 01 02, K=01, FF → tx 02 FE 03.
  - Decrypt: H=03, N=02, FE 03, K=01, FF → tx 02 01 02.
- Errors:
  - H=00, N=00 → tx 00, err=1.
  - H=00, N=MAX_DATA+1 → tx 00, err=1.
  - Next valid header clears err.
- Backpressure: hold tx_busy=1 for 500 cycles after each strobe → exactly N+1 strobes, no duplicates, no lost bytes. During CRYPT/SEND, rx_ack=0 while rx_ready=1.
- Reset mid-data: drop nReset after 2 of 5 data bytes → outputs at reset values; a following full valid frame produces the correct response.

Source files
------------

// File: rtl/xor_frame_cipher.sv
// Framed XOR cipher engine between the UART receiver and sender byte interfaces.
// Receives header/length/data/key, encrypts or decrypts with a repeating key
// (optionally chained), returns a length-prefixed result or a single 0x00 on
// a bad length. Plaintext and result buffers are readable via a registered port.
module xor_frame_cipher #(
  parameter int unsigned MAX_DATA = 100,
  parameter int unsigned MAX_KEY  = 4
) (
  input  logic       Clk_100M,
  input  logic       nReset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ack,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic [7:0] view_idx,
  output logic [7:0] view_plain,
  output logic [7:0] view_result,
  output logic       busy,
  output logic       err,
  output logic       frame_done
);

  localparam int unsigned AW = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;
  localparam int unsigned KW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;
  localparam logic [8:0]  MAX_D9 = 9'(MAX_DATA);
  localparam logic [8:0]  MAX_K9 = 9'(MAX_KEY);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_LEN, S_GET_DATA, S_GET_KLEN, S_GET_KEY,
    S_CRYPT, S_SEND_LEN, S_SEND_DATA, S_SEND_ERR
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] kidx_q, kidx_d;
  logic [7:0] n_q, n_d;
  logic [7:0] k_q, k_d;
  logic       chain_q, chain_d;
  logic       decrypt_q, decrypt_d;
  logic [7:0] cv_q, cv_d;
  logic       err_q, err_d;
  logic       rx_ack_q, rx_ack_d;
  logic       tx_send_q, tx_send_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       pending_q, pending_d;
  logic       frame_done_q, frame_done_d;
  logic       busy_q, busy_d;
  logic [7:0] view_plain_q, view_result_q;

  logic [7:0] plain_mem [MAX_DATA];
  logic [7:0] res_mem   [MAX_DATA];
  logic [7:0] key_mem   [MAX_KEY];

  logic       plain_we, res_we, key_we;
  logic       rx_state, accept, can_send;
  logic [7:0] cur_plain, cur_key, cur_res, crypt_byte;

  // Next-state, handshake and buffer-write decode
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    kidx_d       = kidx_q;
    n_d          = n_q;
    k_d          = k_q;
    chain_d      = chain_q;
    decrypt_d    = decrypt_q;
    cv_d         = cv_q;
    err_d        = err_q;
    rx_ack_d     = rx_ack_q;
    tx_send_d    = 1'b0;
    tx_data_d    = tx_data_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    plain_we     = 1'b0;
    res_we       = 1'b0;
    key_we       = 1'b0;

    cur_plain  = plain_mem[idx_q[AW-1:0]];
    cur_res    = res_mem[idx_q[AW-1:0]];
    cur_key    = key_mem[kidx_q[KW-1:0]];
    crypt_byte = cur_plain ^ cur_key ^ (chain_q ? cv_q : 8'h00);

    rx_state = (state_q == S_IDLE) || (state_q == S_GET_LEN) || (state_q == S_GET_DATA) ||
               (state_q == S_GET_KLEN) || (state_q == S_GET_KEY);
    accept   = rx_state && rx_ready && !rx_ack_q;
    // A new strobe only after busy has been seen high since the previous one
    can_send = !tx_busy && !pending_q;

    if (accept) begin
      rx_ack_d = 1'b1;
    end else if (rx_ack_q && !rx_ready) begin
      rx_ack_d = 1'b0;
    end
    if (tx_busy) begin
      pending_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          chain_d   = rx_data[0];
          decrypt_d = rx_data[1];
          err_d     = 1'b0;
          state_d   = S_GET_LEN;
        end
      end
      S_GET_LEN: begin
        if (accept) begin
          n_d   = rx_data;
          idx_d = 8'd0;
          if ((rx_data == 8'd0) || ({1'b0, rx_data} > MAX_D9)) begin
            err_d   = 1'b1;
            state_d = S_SEND_ERR;
          end else begin
            state_d = S_GET_DATA;
          end
        end
      end
      S_GET_DATA: begin
        if (accept) begin
          plain_we = 1'b1;
          if (idx_q == n_q - 8'd1) begin
            state_d = S_GET_KLEN;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      S_GET_KLEN: begin
        if (accept) begin
          k_d    = rx_data;
          kidx_d = 8'd0;
          idx_d  = 8'd0;
          if ((rx_data == 8'd0) || ({1'b0, rx_data} > MAX_K9)) begin
            err_d   = 1'b1;
            state_d = S_SEND_ERR;
          end else begin
            state_d = S_GET_KEY;
          end
        end
      end
      S_GET_KEY: begin
        if (accept) begin
          key_we = 1'b1;
          if (kidx_q == k_q - 8'd1) begin
            kidx_d  = 8'd0;
            idx_d   = 8'd0;
            cv_d    = 8'h00;
            state_d = S_CRYPT;
          end else begin
            kidx_d = kidx_q + 8'd1;
          end
        end
      end
      S_CRYPT: begin
        res_we = 1'b1;
        cv_d   = decrypt_q ? cur_plain : crypt_byte;
        kidx_d = (kidx_q == k_q - 8'd1) ? 8'd0 : kidx_q + 8'd1;
        if (idx_q == n_q - 8'd1) begin
          idx_d   = 8'd0;
          state_d = S_SEND_LEN;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      S_SEND_LEN: begin
        if (can_send) begin
          tx_send_d = 1'b1;
          tx_data_d = n_q;
          pending_d = 1'b1;
          idx_d     = 8'd0;
          state_d   = S_SEND_DATA;
        end
      end
      S_SEND_DATA: begin
        if (idx_q == n_q) begin
          if (tx_send_q) begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else if (can_send) begin
          tx_send_d = 1'b1;
          tx_data_d = cur_res;
          pending_d = 1'b1;
          idx_d     = idx_q + 8'd1;
        end
      end
      S_SEND_ERR: begin
        if (idx_q == 8'd0) begin
          if (can_send) begin
            tx_send_d = 1'b1;
            tx_data_d = 8'h00;
            pending_d = 1'b1;
            idx_d     = 8'd1;
          end
        end else if (tx_send_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Control and output registers
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      state_q      <= S_IDLE;
      idx_q        <= 8'd0;
      kidx_q       <= 8'd0;
      n_q          <= 8'd0;
      k_q          <= 8'd0;
      chain_q      <= 1'b0;
      decrypt_q    <= 1'b0;
      cv_q         <= 8'h00;
      err_q        <= 1'b0;
      rx_ack_q     <= 1'b0;
      tx_send_q    <= 1'b0;
      tx_data_q    <= 8'h00;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      kidx_q       <= kidx_d;
      n_q          <= n_d;
      k_q          <= k_d;
      chain_q      <= chain_d;
      decrypt_q    <= decrypt_d;
      cv_q         <= cv_d;
      err_q        <= err_d;
      rx_ack_q     <= rx_ack_d;
      tx_send_q    <= tx_send_d;
      tx_data_q    <= tx_data_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  // Buffer storage; contents persist across frames and are not reset
  always_ff @(posedge Clk_100M) begin
    if (plain_we) plain_mem[idx_q[AW-1:0]]  <= rx_data;
    if (res_we)   res_mem[idx_q[AW-1:0]]    <= crypt_byte;
    if (key_we)   key_mem[kidx_q[KW-1:0]]   <= rx_data;
  end

  // Registered display read port; out-of-range indices read as zero
  always_ff @(posedge Clk_100M or negedge nReset) begin
    if (!nReset) begin
      view_plain_q  <= 8'h00;
      view_result_q <= 8'h00;
    end else if ({1'b0, view_idx} < MAX_D9) begin
      view_plain_q  <= plain_mem[view_idx[AW-1:0]];
      view_result_q <= res_mem[view_idx[AW-1:0]];
    end else begin
      view_plain_q  <= 8'h00;
      view_result_q <= 8'h00;
    end
  end

  assign rx_ack      = rx_ack_q;
  assign tx_data     = tx_data_q;
  assign tx_send     = tx_send_q;
  assign view_plain  = view_plain_q;
  assign view_result = view_result_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_xor_frame_cipher.sv
// Scoreboard bench for xor_frame_cipher: expected tx bytes are queued when a
// frame is issued, and a monitor pops and compares on every tx_send strobe.
module tb_xor_frame_cipher;

  logic       Clk_100M = 1'b0;
  logic       nReset   = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_ready = 1'b0;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy  = 1'b0;
  logic [7:0] view_idx = 8'h00;
  logic [7:0] view_plain, view_result;
  logic       busy, err, frame_done;

  int tests    = 0;
  int fails    = 0;
  int strobes  = 0;
  int fd_cnt   = 0;
  int busy_len = 3;
  bit prev_send = 1'b0;
  bit hold_rx   = 1'b0;
  int hold_target = 0;

  logic [7:0] exp_q [$];
  logic [7:0] stim  [$];
  logic [7:0] expv  [$];

  xor_frame_cipher #(.MAX_DATA(100), .MAX_KEY(4)) dut (
    .Clk_100M(Clk_100M), .nReset(nReset),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .view_idx(view_idx), .view_plain(view_plain), .view_result(view_result),
    .busy(busy), .err(err), .frame_done(frame_done)
  );

  always #5 Clk_100M = ~Clk_100M;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Sender model: busy for busy_len cycles after each strobe
  always @(negedge Clk_100M) begin
    if (nReset && tx_send) begin
      tx_busy = 1'b1;
      repeat (busy_len) @(negedge Clk_100M);
      tx_busy = 1'b0;
    end
  end

  // Monitor: compare every strobed byte against the scoreboard queue
  always @(negedge Clk_100M) begin
    if (nReset && tx_send) begin
      strobes++;
      check("tx_no_back_to_back", int'(prev_send), 0);
      if (exp_q.size() == 0) begin
        check("tx_unexpected_byte", int'(tx_data), 256);
      end else begin
        check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
      end
    end
    if (nReset && frame_done) fd_cnt++;
    prev_send = nReset && tx_send;
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    @(negedge Clk_100M);
    rx_data  = b;
    rx_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk_100M);
      if (rx_ack) begin ok = 1'b1; break; end
    end
    if (!ok) check("rx_ack_rise_timeout", 0, 1);
    rx_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge Clk_100M);
      if (!rx_ack) begin ok = 1'b1; break; end
    end
    if (!ok) check("rx_ack_fall_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok, ack_bad;
    ok = 1'b0;
    ack_bad = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge Clk_100M);
      #1;
      if (hold_rx && rx_ready && busy && rx_ack) ack_bad = 1'b1;
      if (hold_rx && strobes >= hold_target) rx_ready = 1'b0;
      if (!busy && exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) check("frame_completion_timeout", 0, 1);
    if (hold_rx) check("rx_ack_low_in_crypt_send", int'(ack_bad), 0);
  endtask

  // Issue stim, expect expv on tx; optionally check one frame_done pulse
  task automatic do_frame(input string name, input bit valid);
    foreach (expv[i]) exp_q.push_back(expv[i]);
    fd_cnt = 0;
    if (hold_rx) hold_target = strobes + expv.size();
    foreach (stim[i]) send_byte(stim[i]);
    if (hold_rx) begin
      @(negedge Clk_100M);
      rx_data  = 8'h55;
      rx_ready = 1'b1;
    end
    wait_done();
    repeat (2) @(negedge Clk_100M);
    if (valid) check({name, "_frame_done"}, fd_cnt, 1);
  endtask

  task automatic check_reset();
    check("rst_rx_ack", int'(rx_ack), 0);
    check("rst_tx_send", int'(tx_send), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_view_plain", int'(view_plain), 0);
    check("rst_view_result", int'(view_result), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(negedge Clk_100M);
    check_reset();
    nReset = 1'b1;
    repeat (2) @(negedge Clk_100M);

    // Basic
    stim = '{8'h00, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h20};
    expv = '{8'h03, 8'h61, 8'h62, 8'h63};
    do_frame("basic", 1'b1);
    view_idx = 8'd1;
    @(negedge Clk_100M);
    check("view_plain_idx1", int'(view_plain), 'h42);
    check("view_result_idx1", int'(view_result), 'h62);
    view_idx = 8'd100;
    @(negedge Clk_100M);
    check("view_plain_oob", int'(view_plain), 0);
    check("view_result_oob", int'(view_result), 0);

    // Key wrap
    stim = '{8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h0F, 8'hF0};
    expv = '{8'h05, 8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h0F};
    do_frame("keywrap", 1'b1);

    // Chain round trip
    stim = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'hFF};
    expv = '{8'h02, 8'hFE, 8'h03};
    do_frame("chain_enc", 1'b1);
    stim = '{8'h03, 8'h02, 8'hFE, 8'h03, 8'h01, 8'hFF};
    expv = '{8'h02, 8'h01, 8'h02};
    do_frame("chain_dec", 1'b1);

    // Length errors
    stim = '{8'h00, 8'h00};
    expv = '{8'h00};
    do_frame("err_n0", 1'b0);
    check("err_after_n0", int'(err), 1);
    stim = '{8'h00, 8'd101};
    expv = '{8'h00};
    do_frame("err_nmax", 1'b0);
    check("err_after_nmax", int'(err), 1);
    stim = '{8'h00, 8'h01, 8'hAA, 8'h00};
    expv = '{8'h00};
    do_frame("err_k0", 1'b0);
    check("err_after_k0", int'(err), 1);
    stim = '{8'h00, 8'h01, 8'hAA, 8'h05};
    expv = '{8'h00};
    do_frame("err_kmax", 1'b0);
    check("err_after_kmax", int'(err), 1);

    // Decrypt bit ignored without chaining; also clears err
    stim = '{8'h02, 8'h02, 8'h10, 8'h20, 8'h01, 8'h01};
    expv = '{8'h02, 8'h11, 8'h21};
    do_frame("nochain_dec", 1'b1);
    check("err_cleared", int'(err), 0);

    // Backpressure with a receiver holding a byte through CRYPT/SEND
    busy_len = 500;
    hold_rx  = 1'b1;
    base     = strobes;
    stim = '{8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02, 8'h01, 8'h02};
    expv = '{8'h03, 8'h11, 8'h33, 8'h02};
    do_frame("backpressure", 1'b1);
    check("backpressure_strobes", strobes - base, 4);
    hold_rx  = 1'b0;
    busy_len = 3;
    repeat (10) @(negedge Clk_100M);

    // Reset in the middle of the data phase
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge Clk_100M);
    nReset = 1'b0;
    #1;
    check_reset();
    repeat (3) @(negedge Clk_100M);
    nReset = 1'b1;
    repeat (2) @(negedge Clk_100M);
    stim = '{8'h00, 8'h03, 8'h41, 8'h42, 8'h43, 8'h01, 8'h20};
    expv = '{8'h03, 8'h61, 8'h62, 8'h63};
    do_frame("after_reset", 1'b1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
